adc_multi_capture: RTL and testbench
====================================

Name: adc_multi_capture

Overview:
- Parametrised multi-channel ADC capture stage in the CLK domain; successor to the fixed 16-channel pass-through capture.
- Takes one common-strobe sample vector for NUM_CH channels and applies per-channel boxcar decimation by 2^dec_shift.
- Snapshots each decimated frame and serialises it as a valid/ready stream tagged with channel index and start/end-of-frame, for the acquisition FIFO/packetiser.

Parameters:
- NUM_CH, 16, number of ADC channels (≥2)
- DATA_W, 16, sample width, signed two's complement
- MAX_SHIFT, 7, largest allowed dec_shift; ratio up to 2^MAX_SHIFT
- CH_W, $clog2(NUM_CH), channel index width (derived)
- ACC_W, DATA_W+MAX_SHIFT, accumulator width (derived)

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable
- dec_shift  in  $clog2(MAX_SHIFT+1)  decimation exponent; values >MAX_SHIFT clamp to MAX_SHIFT
- test_mode  in  1  select test pattern (only with CAP_TESTPAT_EN)
- sample_valid  in  1  strobe: all channels valid this cycle
- sample_data  in  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  decimated sample
- m_chan  out  CH_W  channel index of beat
- m_sof  out  1  high on channel-0 beat
- m_eof  out  1  high on channel NUM_CH-1 beat
- ovf_count  out  16  dropped-frame counter, saturating
- busy  out  1  serialiser in SEND

Behaviour:
- Reset (asynchronous, RESET_n low): accumulators=0, sample counter=0, state=IDLE, m_valid=0, m_data=0, m_chan=0, m_sof=0, m_eof=0, ovf_count=0, busy=0, latched shift=0.
- Shift latch: dec_shift is latched at the first accepted sample of each window (counter==0). Changes mid-window have no effect until the next window.
- Accumulation: on each sample_valid && enable, acc[c] += sign-extended sample; counter++.
- Dump: on the sample where counter==2^shift-1, result[c] = (acc[c]+sample[c]) >>> shift, truncated to DATA_W (arithmetic, rounds toward −inf).
  - Accumulators and counter clear on that same edge.
  - shift=0 means every sample dumps (pass-through).
- enable low: accumulators and counter clear on the next edge; the frame currently in SEND completes normally.
- Serialiser FSM:
  - IDLE: on dump, load shadow[] from result[], set ch_idx=0, go to SEND. m_valid rises in the cycle after the dump edge (latency 1 clock from the final sample).
  - SEND: m_valid=1, m_data=shadow[ch_idx], m_chan=ch_idx, m_sof=(ch_idx==0), m_eof=(ch_idx==NUM_CH-1).
    - On m_valid&&m_ready: ch_idx++.
    - After the last beat: return to IDLE.
  - Beat outputs stay stable while m_valid&&!m_ready.
- Dump during SEND: the new frame is dropped, shadow is untouched, ovf_count++ (saturates at 0xFFFF).
- Exception: if the dump coincides with the last-beat handshake, the frame is accepted. Shadow reloads, ch_idx=0, state stays SEND, and m_valid stays high with no gap.
- m_ready high with m_valid low is ignored.
- busy = (state==SEND).

Optional Feature:
- Macro: CAP_TESTPAT_EN.
- Defined: when test_mode=1, sample_data is replaced before accumulation. Channel c input = (tp_cnt + c) mod 2^DATA_W.
  - tp_cnt is a DATA_W counter that increments on each sample_valid&&enable and is reset to 0.
  - Decimation and serialisation are unchanged.
- Undefined: test_mode is ignored and no tp_cnt register exists.

Decomposition:
- Package adc_cap_pkg holds:
  - the state enum (IDLE, SEND)
  - an OVF_W=16 constant
  - a function that clamps dec_shift
- Sub-module adc_boxcar_acc: one channel's accumulator with the dump result. The top instantiates it NUM_CH times in a generate loop; counter and shift latch stay in the top.

Test Plan:
- Pass-through: shift=0, NUM_CH=16, m_ready=1, one sample_valid with channel c=c*100 → m_valid rises next cycle. Then 16 consecutive beats m_data=0,100,…,1500 with m_chan=0..15, m_sof on beat 0, m_eof on beat 15.
- Decimation/sign: shift=2, channel 0 fed −3,−3,−3,−2 → sum −11 >>> 2 = −3 emitted. Channel 1 fed 0x7FFF×4 → 0x7FFF (no overflow).
- Backpressure: m_ready toggles 1,0,0,1 during a frame → each beat held stable while stalled, no beats lost or duplicated, ovf_count stays 0.
- Overflow: shift=0, m_ready=0, sample_valid every cycle for 5 cycles → first frame held on m_chan=0, ovf_count=4.
  - Saturation: force 70000 drops → ovf_count=0xFFFF.
- Back-to-back: dump arrives on the edge of the last-beat handshake → m_valid stays high, next beat m_sof=1, ovf_count unchanged.
- Reset/enable: assert RESET_n low mid-frame (ch_idx=7) → all outputs 0 immediately. Drop enable mid-window with shift=3 after 5 samples → next frame uses only post-enable samples.
- Test pattern (CAP_TESTPAT_EN defined): shift=0, test_mode=1 → first frame channel c = c, second frame = c+1.

Source files
------------

// File: rtl/adc_multi_capture_pkg.sv
// Shared types and helpers for the multi-channel ADC capture stage.
package adc_cap_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int OVF_W = 16;

    // Requested decimation exponents above the supported maximum saturate.
    function automatic int unsigned clamp_shift(input int unsigned req,
                                                input int unsigned max_shift);
        return (req > max_shift) ? max_shift : req;
    endfunction

endpackage

// File: rtl/adc_multi_capture_if.sv
// Output beat stream of the capture stage.
// Handshake: a beat transfers on a clock edge where m_valid && m_ready; while
// m_valid is high and m_ready low every beat field holds its value; m_ready
// with m_valid low has no effect.
interface adc_cap_stream_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 4
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CH_W-1:0]   m_chan;
    logic              m_sof;
    logic              m_eof;

    modport master (
        output m_valid, m_data, m_chan, m_sof, m_eof,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_chan, m_sof, m_eof,
        output m_ready
    );
endinterface

// File: rtl/adc_boxcar_acc.sv
// One channel's boxcar accumulator; the result is the window sum including
// the current sample, arithmetically shifted down to DATA_W.
module adc_boxcar_acc
    import adc_cap_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_SHIFT = 7,
    parameter int SH_W      = $clog2(MAX_SHIFT + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic              dump_i,
    input  logic [SH_W-1:0]   shift_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] result_o
);
    localparam int ACC_W = DATA_W + MAX_SHIFT;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;

    // ACC_W is sized so 2^MAX_SHIFT full-scale samples cannot wrap.
    assign sum      = acc_q + $signed({{MAX_SHIFT{sample_i[DATA_W-1]}}, sample_i});
    assign shifted  = sum >>> shift_i;
    assign result_o = shifted[DATA_W-1:0];

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (accept_i) begin
            acc_d = dump_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/adc_multi_capture.sv
// Multi-channel ADC capture: per-channel boxcar decimation by 2^dec_shift and
// frame serialisation onto a valid/ready stream. Optional test pattern source
// is compiled in with `define CAP_TESTPAT_EN.
module adc_multi_capture
    import adc_cap_pkg::*;
#(
    parameter int NUM_CH    = 16,
    parameter int DATA_W    = 16,
    parameter int MAX_SHIFT = 7,
    parameter int CH_W      = $clog2(NUM_CH),
    parameter int SH_W      = $clog2(MAX_SHIFT + 1)
) (
    input  logic                     CLK,
    input  logic                     RESET_n,
    input  logic                     enable,
    input  logic [SH_W-1:0]          dec_shift,
    input  logic                     test_mode,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    adc_cap_stream_if.master         m,
    output logic [OVF_W-1:0]         ovf_count,
    output logic                     busy
);
    logic                     accept;
    logic                     dump;
    logic [SH_W-1:0]          shift_req;
    logic [SH_W-1:0]          eff_shift;
    logic [SH_W-1:0]          shift_q;
    logic [MAX_SHIFT-1:0]     cnt_q;
    logic [MAX_SHIFT:0]       win_last;
    logic [NUM_CH*DATA_W-1:0] sample_in;
    logic [NUM_CH*DATA_W-1:0] result;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_idx_q, ch_idx_d;
    logic [OVF_W-1:0]         ovf_q, ovf_d;
    logic [DATA_W-1:0]        shadow_q [NUM_CH];
    logic                     load;
    logic                     drop;
    logic                     hs;
    logic                     last_beat;

    assign accept    = sample_valid && enable;
    assign shift_req = SH_W'(clamp_shift(32'(dec_shift), MAX_SHIFT));
    // The window length is fixed by the exponent seen on its first sample.
    assign eff_shift = (cnt_q == '0) ? shift_req : shift_q;
    assign win_last  = ((MAX_SHIFT+1)'(1) << eff_shift) - (MAX_SHIFT+1)'(1);
    assign dump      = accept && ({1'b0, cnt_q} == win_last);

`ifdef CAP_TESTPAT_EN
    logic [DATA_W-1:0] tp_cnt_q;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            tp_cnt_q <= '0;
        end else if (accept) begin
            tp_cnt_q <= tp_cnt_q + DATA_W'(1);
        end
    end

    always_comb begin
        sample_in = sample_data;
        if (test_mode) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sample_in[c*DATA_W +: DATA_W] = tp_cnt_q + DATA_W'(c);
            end
        end
    end
`else
    assign sample_in = sample_data;
`endif

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            if (!enable) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= dump ? '0 : cnt_q + MAX_SHIFT'(1);
            end
            if (accept && cnt_q == '0) begin
                shift_q <= shift_req;
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_boxcar_acc #(
            .DATA_W    (DATA_W),
            .MAX_SHIFT (MAX_SHIFT),
            .SH_W      (SH_W)
        ) u_acc (
            .clk_i    (CLK),
            .rst_ni   (RESET_n),
            .clear_i  (!enable),
            .accept_i (accept),
            .dump_i   (dump),
            .shift_i  (eff_shift),
            .sample_i (sample_in[c*DATA_W +: DATA_W]),
            .result_o (result[c*DATA_W +: DATA_W])
        );
    end

    assign hs        = (state_q == SEND) && m.m_ready;
    assign last_beat = (ch_idx_q == CH_W'(NUM_CH - 1));

    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        load     = 1'b0;
        drop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump) begin
                    load     = 1'b1;
                    ch_idx_d = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // A frame landing on the final handshake chains on with no gap.
                if (hs && last_beat) begin
                    ch_idx_d = '0;
                    if (dump) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (hs) begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                    end
                    drop = dump;
                end
            end
            default: begin
                state_d  = IDLE;
                ch_idx_d = '0;
            end
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop && ovf_q != '1) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q  <= IDLE;
            ch_idx_q <= '0;
            ovf_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            ovf_q    <= ovf_d;
            if (load) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    shadow_q[c] <= result[c*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign m.m_valid = (state_q == SEND);
    assign m.m_data  = (state_q == SEND) ? shadow_q[ch_idx_q] : '0;
    assign m.m_chan  = ch_idx_q;
    assign m.m_sof   = (state_q == SEND) && (ch_idx_q == '0);
    assign m.m_eof   = (state_q == SEND) && last_beat;
    assign ovf_count = ovf_q;
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_adc_multi_capture.sv
// Directed bench for adc_multi_capture with default parameters
// (16 channels, 16-bit samples, MAX_SHIFT 7).
module tb_adc_multi_capture;
    localparam int NUM_CH = 16;
    localparam int DATA_W = 16;

    logic                     CLK;
    logic                     RESET_n;
    logic                     enable;
    logic [2:0]               dec_shift;
    logic                     test_mode;
    logic                     sample_valid;
    logic [NUM_CH*DATA_W-1:0] sample_data;
    logic [15:0]              ovf_count;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    adc_cap_stream_if #(.DATA_W(DATA_W), .CH_W(4)) s_if ();

    adc_multi_capture dut (
        .CLK          (CLK),
        .RESET_n      (RESET_n),
        .enable       (enable),
        .dec_shift    (dec_shift),
        .test_mode    (test_mode),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .m            (s_if.master),
        .ovf_count    (ovf_count),
        .busy         (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Channel c gets base + c*mult.
    task automatic set_frame(input int base, input int mult);
        for (int c = 0; c < NUM_CH; c++) begin
            sample_data[c*DATA_W +: DATA_W] = DATA_W'(base + c * mult);
        end
    endtask

    task automatic drain();
        int guard;
        s_if.m_ready = 1'b1;
        guard = 0;
        while (s_if.m_valid === 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        check("drain_idle", {31'd0, s_if.m_valid}, 32'd0);
    endtask

    task automatic pulse_reset();
        RESET_n = 1'b0;
        #1;
        tick();
        RESET_n = 1'b1;
        tick();
    endtask

    initial begin
        int k;
        int guard;
        logic [3:0] rpat;

        RESET_n      = 1'b0;
        enable       = 1'b0;
        dec_shift    = 3'd0;
        test_mode    = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        s_if.m_ready = 1'b0;
        #2;
        check("rst_valid", {31'd0, s_if.m_valid}, 32'd0);
        check("rst_data",  {16'd0, s_if.m_data},  32'd0);
        check("rst_chan",  {28'd0, s_if.m_chan},  32'd0);
        check("rst_sof",   {31'd0, s_if.m_sof},   32'd0);
        check("rst_eof",   {31'd0, s_if.m_eof},   32'd0);
        check("rst_ovf",   {16'd0, ovf_count},    32'd0);
        check("rst_busy",  {31'd0, busy},         32'd0);
        tick();
        tick();
        RESET_n = 1'b1;
        tick();

        // Pass-through: every sample dumps, 16 beats follow one clock later.
        enable       = 1'b1;
        s_if.m_ready = 1'b1;
        set_frame(0, 100);
        sample_valid = 1'b1;
        check("pt_not_early", {31'd0, s_if.m_valid}, 32'd0);
        tick();
        sample_valid = 1'b0;
        for (int b = 0; b < NUM_CH; b++) begin
            check("pt_valid", {31'd0, s_if.m_valid}, 32'd1);
            check("pt_data",  {16'd0, s_if.m_data},  32'(b * 100));
            check("pt_chan",  {28'd0, s_if.m_chan},  32'(b));
            check("pt_sof",   {31'd0, s_if.m_sof},   (b == 0) ? 32'd1 : 32'd0);
            check("pt_eof",   {31'd0, s_if.m_eof},   (b == 15) ? 32'd1 : 32'd0);
            tick();
        end
        check("pt_end_valid", {31'd0, s_if.m_valid}, 32'd0);
        check("pt_end_busy",  {31'd0, busy},         32'd0);

        // Decimation by 4 with negative values and full-scale positives.
        dec_shift = 3'd2;
        for (int i = 0; i < 4; i++) begin
            set_frame(0, 0);
            sample_data[0 +: 16]  = (i == 3) ? 16'hFFFE : 16'hFFFD;
            sample_data[16 +: 16] = 16'h7FFF;
            sample_valid = 1'b1;
            tick();
            if (i == 2) check("dec_not_early", {31'd0, s_if.m_valid}, 32'd0);
        end
        sample_valid = 1'b0;
        check("dec_valid", {31'd0, s_if.m_valid}, 32'd1);
        check("dec_ch0",   {16'd0, s_if.m_data},  32'h0000FFFD);
        tick();
        check("dec_ch1",   {16'd0, s_if.m_data},  32'h00007FFF);
        tick();
        check("dec_ch2",   {16'd0, s_if.m_data},  32'd0);
        drain();

        // Backpressure with ready pattern 1,0,0,1.
        dec_shift    = 3'd0;
        rpat         = 4'b1001;
        set_frame(1000, 1);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        k     = 0;
        guard = 0;
        while (k < NUM_CH && guard < 100) begin
            s_if.m_ready = rpat[guard % 4];
            check("bp_valid", {31'd0, s_if.m_valid}, 32'd1);
            check("bp_chan",  {28'd0, s_if.m_chan},  32'(k));
            check("bp_data",  {16'd0, s_if.m_data},  32'(1000 + k));
            if (s_if.m_ready) k++;
            tick();
            guard++;
        end
        check("bp_beats", 32'(k), 32'd16);
        check("bp_done",  {31'd0, s_if.m_valid}, 32'd0);
        check("bp_ovf",   {16'd0, ovf_count},    32'd0);

        // Overflow: one frame held, four more dropped.
        s_if.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_frame(1 + i * 50, 3);
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        check("ovf_valid", {31'd0, s_if.m_valid}, 32'd1);
        check("ovf_chan",  {28'd0, s_if.m_chan},  32'd0);
        check("ovf_data0", {16'd0, s_if.m_data},  32'd1);
        check("ovf_count", {16'd0, ovf_count},    32'd4);
        s_if.m_ready = 1'b1;
        tick();
        check("ovf_data1", {16'd0, s_if.m_data},  32'd4);
        drain();

        // Saturation of the drop counter.
        s_if.m_ready = 1'b0;
        sample_valid = 1'b1;
        repeat (70000) tick();
        sample_valid = 1'b0;
        check("ovf_sat", {16'd0, ovf_count}, 32'h0000FFFF);
        RESET_n = 1'b0;
        #1;
        check("ovf_rst", {16'd0, ovf_count}, 32'd0);
        tick();
        RESET_n = 1'b1;
        tick();

        // Back-to-back: new dump on the last-beat handshake edge.
        s_if.m_ready = 1'b1;
        set_frame(200, 1);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int b = 0; b < NUM_CH; b++) begin
            check("b2b_a_data", {16'd0, s_if.m_data}, 32'(200 + b));
            if (b == 15) begin
                set_frame(500, 1);
                sample_valid = 1'b1;
            end
            tick();
        end
        sample_valid = 1'b0;
        check("b2b_valid", {31'd0, s_if.m_valid}, 32'd1);
        check("b2b_sof",   {31'd0, s_if.m_sof},   32'd1);
        check("b2b_data",  {16'd0, s_if.m_data},  32'd500);
        check("b2b_ovf",   {16'd0, ovf_count},    32'd0);
        tick();
        check("b2b_data1", {16'd0, s_if.m_data},  32'd501);
        drain();

        // Asynchronous reset mid-frame at channel 7.
        set_frame(300, 1);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (7) tick();
        check("mid_chan", {28'd0, s_if.m_chan}, 32'd7);
        check("mid_data", {16'd0, s_if.m_data}, 32'd307);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, s_if.m_valid}, 32'd0);
        check("mid_rst_data",  {16'd0, s_if.m_data},  32'd0);
        check("mid_rst_chan",  {28'd0, s_if.m_chan},  32'd0);
        check("mid_rst_sof",   {31'd0, s_if.m_sof},   32'd0);
        check("mid_rst_eof",   {31'd0, s_if.m_eof},   32'd0);
        check("mid_rst_busy",  {31'd0, busy},         32'd0);
        tick();
        RESET_n = 1'b1;
        tick();

        // Enable drop mid-window; later shift change inside window is ignored.
        dec_shift = 3'd3;
        set_frame(1000, 0);
        sample_valid = 1'b1;
        repeat (5) tick();
        sample_valid = 1'b0;
        enable = 1'b0;
        tick();
        enable = 1'b1;
        set_frame(8, 0);
        for (int i = 0; i < 8; i++) begin
            sample_valid = 1'b1;
            tick();
            if (i == 0) dec_shift = 3'd0;
            if (i == 6) check("en_not_early", {31'd0, s_if.m_valid}, 32'd0);
        end
        sample_valid = 1'b0;
        check("en_valid", {31'd0, s_if.m_valid}, 32'd1);
        check("en_data",  {16'd0, s_if.m_data},  32'd8);
        drain();

`ifdef CAP_TESTPAT_EN
        pulse_reset();
        enable    = 1'b1;
        dec_shift = 3'd0;
        test_mode = 1'b1;
        set_frame(0, 0);
        for (int f = 0; f < 2; f++) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            for (int b = 0; b < NUM_CH; b++) begin
                check("tp_data", {16'd0, s_if.m_data}, 32'(b + f));
                tick();
            end
        end
        test_mode = 1'b0;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
